// File: rtl/decoder_3to8.sv
// Binary-to-one-hot 3-to-8 decoder with a registered capture path,
// selection-change flag and per-line saturating usage counters.

module decoder_3to8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sel,
    output logic [7:0] y,
    input  logic       en,
    output logic [7:0] y_q,
    output logic [2:0] sel_q,
    output logic       chg,
    input  logic       cnt_clr,
    input  logic [2:0] cnt_sel,
    output logic [7:0] cnt_out
);

    logic [7:0]      y_d;
    logic [2:0]      sel_d;
    logic            chg_d;
    logic            chg_q;
    logic            first_d;
    logic            first_q;
    logic [7:0][7:0] cnt_d;
    logic [7:0][7:0] cnt_q;

    // Pure function of sel so it stays valid with the clocked inputs floating.
    assign y = 8'b0000_0001 << sel;

    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        chg_d   = 1'b0;
        first_d = first_q;
        cnt_d   = cnt_q;
        if (en) begin
            y_d     = y;
            sel_d   = sel;
            chg_d   = first_q || (sel != sel_q);
            first_d = 1'b0;
            if (cnt_q[sel] != 8'hFF) begin
                cnt_d[sel] = cnt_q[sel] + 8'd1;
            end
        end
        // Clear wins over a same-edge increment.
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= 8'h00;
            sel_q   <= 3'd0;
            chg_q   <= 1'b0;
            first_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            chg_q   <= chg_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    assign chg     = chg_q;
    assign cnt_out = cnt_q[cnt_sel];

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8.

module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic [7:0] y;
    logic       en;
    logic [7:0] y_q;
    logic [2:0] sel_q;
    logic       chg;
    logic       cnt_clr;
    logic [2:0] cnt_sel;
    logic [7:0] cnt_out;

    int errors = 0;
    int checks = 0;

    decoder_3to8 dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .y       (y),
        .en      (en),
        .y_q     (y_q),
        .sel_q   (sel_q),
        .chg     (chg),
        .cnt_clr (cnt_clr),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode_sweep();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            checks++;
            if (y !== exp_tab[i]) begin
                errors++;
                $display("FAIL decode_sweep sel=%0d y=%h expected=%h", i, y, exp_tab[i]);
            end
        end
    endtask

    task automatic test_reset();
        en      = 1'b0;
        cnt_clr = 1'b0;
        cnt_sel = 3'd0;
        sel     = 3'd0;
        rst     = 1'b1;
        tick();
        tick();
        checks++;
        if (y_q !== 8'h00) begin errors++; $display("FAIL reset_y_q got=%h expected=00", y_q); end
        checks++;
        if (sel_q !== 3'd0) begin errors++; $display("FAIL reset_sel_q got=%0d expected=0", sel_q); end
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg got=%b expected=0", chg); end
        for (int k = 0; k < 8; k++) begin
            cnt_sel = 3'(k);
            #1;
            checks++;
            if (cnt_out !== 8'd0) begin
                errors++;
                $display("FAIL reset_cnt idx=%0d got=%0d expected=0", k, cnt_out);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_capture();
        en  = 1'b1;
        sel = 3'd5;
        tick();
        checks++;
        if (y_q !== 8'h20) begin errors++; $display("FAIL capture_y_q got=%h expected=20", y_q); end
        checks++;
        if (sel_q !== 3'd5) begin errors++; $display("FAIL capture_sel_q got=%0d expected=5", sel_q); end
        checks++;
        if (chg !== 1'b1) begin errors++; $display("FAIL capture_first_chg got=%b expected=1", chg); end
        tick();
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL capture_same_chg got=%b expected=0", chg); end
        cnt_sel = 3'd5;
        #1;
        checks++;
        if (cnt_out !== 8'd2) begin errors++; $display("FAIL capture_cnt5 got=%0d expected=2", cnt_out); end
    endtask

    task automatic test_hold();
        en  = 1'b0;
        sel = 3'd2;
        #1;
        checks++;
        if (y !== 8'h04) begin errors++; $display("FAIL hold_y got=%h expected=04", y); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y_q !== 8'h20 || sel_q !== 3'd5 || chg !== 1'b0) begin
                errors++;
                $display("FAIL hold_regs edge=%0d y_q=%h sel_q=%0d chg=%b expected 20/5/0", i, y_q, sel_q, chg);
            end
        end
        cnt_sel = 3'd2;
        #1;
        checks++;
        if (cnt_out !== 8'd0) begin errors++; $display("FAIL hold_cnt2 got=%0d expected=0", cnt_out); end
    endtask

    task automatic test_back_to_back();
        en  = 1'b1;
        sel = 3'd1;
        tick();
        checks++;
        if (chg !== 1'b1 || y_q !== 8'h02) begin
            errors++;
            $display("FAIL b2b_first chg=%b y_q=%h expected 1/02", chg, y_q);
        end
        sel = 3'd6;
        tick();
        checks++;
        if (chg !== 1'b1 || y_q !== 8'h40) begin
            errors++;
            $display("FAIL b2b_second chg=%b y_q=%h expected 1/40", chg, y_q);
        end
        tick();
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL b2b_repeat chg=%b expected=0", chg); end
        en = 1'b0;
        cnt_sel = 3'd6;
        #1;
        checks++;
        if (cnt_out !== 8'd2) begin errors++; $display("FAIL b2b_cnt6 got=%0d expected=2", cnt_out); end
        cnt_sel = 3'd1;
        #1;
        checks++;
        if (cnt_out !== 8'd1) begin errors++; $display("FAIL b2b_cnt1 got=%0d expected=1", cnt_out); end
    endtask

    task automatic test_saturate();
        en  = 1'b1;
        sel = 3'd3;
        cnt_sel = 3'd3;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 254) begin
                checks++;
                if (cnt_out !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach got=%0d expected=255", cnt_out);
                end
            end
        end
        en = 1'b0;
        #1;
        checks++;
        if (cnt_out !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d expected=255", cnt_out); end
        cnt_sel = 3'd4;
        #1;
        checks++;
        if (cnt_out !== 8'd0) begin errors++; $display("FAIL sat_cnt4 got=%0d expected=0", cnt_out); end
        cnt_sel = 3'd5;
        #1;
        checks++;
        if (cnt_out !== 8'd2) begin errors++; $display("FAIL sat_cnt5 got=%0d expected=2", cnt_out); end
    endtask

    task automatic test_clear();
        cnt_clr = 1'b1;
        en      = 1'b1;
        sel     = 3'd3;
        tick();
        cnt_clr = 1'b0;
        en      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cnt_sel = 3'(k);
            #1;
            checks++;
            if (cnt_out !== 8'd0) begin
                errors++;
                $display("FAIL clear_cnt idx=%0d got=%0d expected=0", k, cnt_out);
            end
        end
        checks++;
        if (y_q !== 8'h08 || sel_q !== 3'd3 || chg !== 1'b0) begin
            errors++;
            $display("FAIL clear_capture y_q=%h sel_q=%0d chg=%b expected 08/3/0", y_q, sel_q, chg);
        end
    endtask

    task automatic test_async_reset();
        en  = 1'b1;
        sel = 3'd7;
        tick();
        cnt_sel = 3'd7;
        #1;
        checks++;
        if (cnt_out !== 8'd1 || chg !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup cnt7=%0d chg=%b expected 1/1", cnt_out, chg);
        end
        sel = 3'd2;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (y_q !== 8'h00 || sel_q !== 3'd0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL arst_regs y_q=%h sel_q=%0d chg=%b expected 00/0/0", y_q, sel_q, chg);
        end
        checks++;
        if (cnt_out !== 8'd0) begin errors++; $display("FAIL arst_cnt7 got=%0d expected=0", cnt_out); end
        checks++;
        if (y !== 8'h04) begin errors++; $display("FAIL arst_y got=%h expected=04", y); end
        sel = 3'd6;
        #1;
        checks++;
        if (y !== 8'h40) begin errors++; $display("FAIL arst_y_track got=%h expected=40", y); end
        tick();
        checks++;
        if (y_q !== 8'h00 || sel_q !== 3'd0 || chg !== 1'b0 || cnt_out !== 8'd0) begin
            errors++;
            $display("FAIL arst_no_capture y_q=%h sel_q=%0d chg=%b cnt=%0d expected 00/0/0/0",
                     y_q, sel_q, chg, cnt_out);
        end
        rst = 1'b0;
        sel = 3'd0;
        tick();
        checks++;
        if (y_q !== 8'h01 || sel_q !== 3'd0 || chg !== 1'b1) begin
            errors++;
            $display("FAIL arst_first_cap y_q=%h sel_q=%0d chg=%b expected 01/0/1", y_q, sel_q, chg);
        end
        tick();
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL arst_second_cap chg=%b expected=0", chg); end
        cnt_sel = 3'd0;
        #1;
        checks++;
        if (cnt_out !== 8'd2) begin errors++; $display("FAIL arst_cnt0 got=%0d expected=2", cnt_out); end
        en = 1'b0;
    endtask

    initial begin
        test_decode_sweep();
        test_reset();
        test_capture();
        test_hold();
        test_back_to_back();
        test_saturate();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
